// File: rtl/seven_seg_scan_if.sv
// Load-side interface of the seven-segment scanner.
//   value    : packed nibbles, value[4i+3:4i] is digit i (digit 0 = rightmost)
//   dp_mask  : decimal point per digit, captured together with value
//   load     : capture request from the core
//   ready    : pending buffer empty
// Handshake: a word transfers on any cycle where load && ready are both high
// at the rising clock edge. value/dp_mask are only sampled on that cycle.
// load while ready is low is ignored and may be dropped freely.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    load;
  logic                    ready;

  modport master (output value, output dp_mask, output load, input ready);
  modport slave  (input value, input dp_mask, input load, output ready);
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for NUM_DIGITS seven-segment digits on one segment bus.
// A loaded word waits in a pending buffer and is copied to the display register
// only when the scan wraps to digit 0, so a frame never mixes two values.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ld          : load handshake (value, dp_mask, load, ready)
//   seg         : {A,B,C,D,E,F,G} of the active digit
//   dp          : decimal point of the active digit
//   digit_en    : one-hot digit enable, all inactive during the dead time
//   frame_tick  : one-cycle pulse when the scan index wraps to 0
// seg, dp and digit_en are active-low when COMMON_ANODE=1.
module seven_seg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 16000,
  parameter int DEAD_CYCLES   = 2,
  parameter int HEX_MODE      = 0,
  parameter int BLANK_LEADING = 1,
  parameter int COMMON_ANODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_if.slave       ld,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int DW    = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DW-1:0]    DEAD_LOAD  = DW'(DEAD_CYCLES);

  logic [PW-1:0]           presc;
  logic [IDX_W-1:0]        idx;
  logic [DW-1:0]           dead;
  logic                    tick_q;

  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_full;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   en_q;

  logic                    slot_end;
  logic                    frame_end;
  logic                    accept;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   en_onehot;

  assign slot_end  = (presc == PRESC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign accept    = ld.load && !pend_full;
  assign ld.ready  = !pend_full;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    // Decimal mode shows a lone G segment (dash) for out-of-range nibbles.
    if (HEX_MODE == 0 && nib > 4'h9) g = 7'b0000001;
    return g;
  endfunction

  // Scan timing: prescaler, digit index, dead-time counter, frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      idx    <= '0;
      dead   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= frame_end;
      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        dead  <= DEAD_LOAD;
      end else begin
        presc <= presc + PW'(1);
        if (dead != '0) dead <= dead - DW'(1);
      end
    end
  end

  // Pending buffer and display register. The copy happens on the same edge
  // that wraps idx to 0, so digit 0 of the new frame already shows it. A word
  // accepted on that edge was not yet pending and waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
      disp_val  <= '0;
      disp_dp   <= '0;
    end else if (frame_end && pend_full) begin
      disp_val  <= pend_val;
      disp_dp   <= pend_dp;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_val  <= ld.value;
      pend_dp   <= ld.dp_mask;
      pend_full <= 1'b1;
    end
  end

  // Active digit selection and leading-zero blanking from the display register.
  // The active digit is blank when it and every digit above it are zero.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    en_onehot = '0;
    cur_blank = (BLANK_LEADING != 0) && (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        cur_nib      = disp_val[4*i +: 4];
        cur_dp       = disp_dp[i];
        en_onehot[i] = 1'b1;
      end
      if (disp_val[4*i +: 4] != 4'h0 && IDX_W'(i) >= idx) cur_blank = 1'b0;
    end
  end

  // Registered outputs in active-high form. digit_en goes dark on the slot's
  // last cycle edge and stays dark while the dead counter runs down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      en_q  <= '0;
    end else begin
      seg_q <= cur_blank ? 7'b0000000 : glyph(cur_nib);
      dp_q  <= cur_dp;
      en_q  <= (slot_end || dead != '0) ? '0 : en_onehot;
    end
  end

  assign seg        = (COMMON_ANODE != 0) ? ~seg_q : seg_q;
  assign dp         = (COMMON_ANODE != 0) ? ~dp_q  : dp_q;
  assign digit_en   = (COMMON_ANODE != 0) ? ~en_q  : en_q;
  assign frame_tick = tick_q;

endmodule
